// File: rtl/manch_pkg.sv
// Manchester line-code constants and decoder state encoding,
// shared between the encoder and decoder sides of the link.
package manch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        HOLD
    } state_t;

    localparam logic       MANCH_IDLE_LVL = 1'b0;
    localparam logic [1:0] MANCH_ONE      = 2'b01;
    localparam logic [1:0] MANCH_ZERO     = 2'b10;

    function automatic logic manch_pair_ok(input logic [1:0] pair);
        return (pair == MANCH_ONE) || (pair == MANCH_ZERO);
    endfunction

endpackage

// File: rtl/manch_pair_dec.sv
// Combinational decode of one Manchester half-pair into a data bit
// and a symbol-valid flag (00 and 11 are not legal symbols).
module manch_pair_dec
    import manch_pkg::*;
(
    input  logic half0,
    input  logic half1,
    output logic dbit,
    output logic valid
);

    assign dbit  = half1;
    assign valid = manch_pair_ok({half0, half1});

endmodule

// File: rtl/manch_dec.sv
// Manchester decoder on clk_2x: recovers an N-bit word LSB first.
// Define MANCH_DEC_ERR_EN to add the code_err invalid-symbol output.
module manch_dec
    import manch_pkg::*;
#(
    parameter int N = 9
) (
    input  logic         clk_2x,
    input  logic         rst,
    input  logic         go,
    input  logic         enc_ser_in,
    output logic [N-1:0] data_out,
    output logic         done,
    output logic         busy
`ifdef MANCH_DEC_ERR_EN
    ,
    output logic         code_err
`endif
);

    localparam int CW = $clog2(N);

    state_t         state;
    state_t         nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   shreg;
    logic [N-1:0]   shifted;
    logic           half0;
    logic           go_q;
    logic           pair_bit;
    logic           last;
    logic           nxt_busy;

`ifdef MANCH_DEC_ERR_EN
    logic pair_valid;
    logic err_flag;

    manch_pair_dec u_pair (
        .half0 (half0),
        .half1 (enc_ser_in),
        .dbit  (pair_bit),
        .valid (pair_valid)
    );
`else
    manch_pair_dec u_pair (
        .half0 (half0),
        .half1 (enc_ser_in),
        .dbit  (pair_bit),
        .valid ()
    );
`endif

    assign shifted  = {pair_bit, shreg[N-1:1]};
    assign last     = (state == SECOND) && go
                      && (cnt == CW'(N - 1));
    assign nxt_busy = (nxt == FIRST) || (nxt == SECOND);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (go && !go_q) nxt = FIRST;
            FIRST:   nxt = go ? SECOND : IDLE;
            SECOND: begin
                if (!go)       nxt = IDLE;
                else if (last) nxt = HOLD;
                else           nxt = FIRST;
            end
            HOLD:    if (!go) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // go_q resets high so a go still asserted across reset
    // must drop and rise again before a frame can start.
    always_ff @(posedge clk_2x or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            go_q     <= 1'b1;
            half0    <= MANCH_IDLE_LVL;
            cnt      <= '0;
            shreg    <= '0;
            data_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= nxt;
            go_q  <= go;
            done  <= last;
            busy  <= nxt_busy;
            if ((state == FIRST) && go) begin
                half0 <= enc_ser_in;
            end
            if ((state == SECOND) && go) begin
                shreg <= shifted;
                cnt   <= cnt + CW'(1);
                if (last) data_out <= shifted;
            end
            if (!nxt_busy) begin
                cnt   <= '0;
                shreg <= '0;
            end
        end
    end

`ifdef MANCH_DEC_ERR_EN
    always_ff @(posedge clk_2x or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            code_err <= 1'b0;
        end else begin
            code_err <= last && (err_flag || !pair_valid);
            if (state == IDLE) begin
                err_flag <= 1'b0;
            end else if ((state == SECOND) && go && !pair_valid) begin
                err_flag <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_manch_dec.sv
// Directed bench for manch_dec: loopback frames, abort, async reset,
// invalid-symbol handling and HOLD behaviour with go left high.
module tb_manch_dec;

    localparam int N = 9;

    logic         clk_2x = 1'b0;
    logic         rst    = 1'b1;
    logic         go     = 1'b0;
    logic         ser    = 1'b0;
    logic [N-1:0] data_out;
    logic         done;
    logic         busy;
`ifdef MANCH_DEC_ERR_EN
    logic         code_err;
`endif

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int base_cnt = 0;

    always #5 clk_2x = ~clk_2x;

    always @(negedge clk_2x) begin
        if (done === 1'b1) done_cnt++;
    end

    manch_dec #(.N(N)) dut (
        .clk_2x     (clk_2x),
        .rst        (rst),
        .go         (go),
        .enc_ser_in (ser),
        .data_out   (data_out),
        .done       (done),
        .busy       (busy)
`ifdef MANCH_DEC_ERR_EN
        ,
        .code_err   (code_err)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Acts as the encoder: go rises, then edge k0+e sees half e.
    // stop_e drops go for edge k0+stop_e; rst_e pulses reset just
    // before edge k0+rst_e; bad_i forces bit bad_i's pair to 11.
    task automatic frame(input logic [N-1:0] w,
                         input int stop_e,
                         input int rst_e,
                         input int bad_i);
        int i;
        @(negedge clk_2x);
        go  = 1'b1;
        ser = 1'b0;
        for (int e = 1; e <= 2 * N; e++) begin
            @(negedge clk_2x);
            if (e == rst_e) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_data", 32'(data_out), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_done", 32'(done), 32'h0);
                rst = 1'b0;
                ser = 1'b0;
                return;
            end
            if (e == stop_e) begin
                go  = 1'b0;
                ser = 1'b0;
                return;
            end
            if (e == 2 * N) begin
                chk("pre_done", 32'(done), 32'h0);
                chk("pre_busy", 32'(busy), 32'h1);
            end
            i   = (e - 1) / 2;
            ser = (e % 2 == 1) ? ~w[i] : w[i];
            if (i == bad_i) ser = 1'b1;
        end
        @(negedge clk_2x);
    endtask

    initial begin
        repeat (2) @(negedge clk_2x);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
`ifdef MANCH_DEC_ERR_EN
        chk("reset_err", 32'(code_err), 32'h0);
`endif
        rst = 1'b0;

        frame(9'h1A5, 0, 0, -1);
        chk("f1a5_done", 32'(done), 32'h1);
        chk("f1a5_data", 32'(data_out), 32'h1A5);
        chk("f1a5_busy", 32'(busy), 32'h0);
        @(negedge clk_2x);
        chk("f1a5_pulse", 32'(done), 32'h0);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);
        chk("f1a5_count", 32'(done_cnt), 32'd1);

        frame(9'h000, 0, 0, -1);
        chk("f000_data", 32'(data_out), 32'h000);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);
        frame(9'h1FF, 0, 0, -1);
        chk("f1ff_data", 32'(data_out), 32'h1FF);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);
        chk("pair_count", 32'(done_cnt), 32'd3);

        frame(9'h0F0, 7, 0, -1);
        @(negedge clk_2x);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        repeat (2 * N + 2) @(negedge clk_2x);
        chk("abort_data", 32'(data_out), 32'h1FF);
        chk("abort_count", 32'(done_cnt), 32'd3);
        frame(9'h055, 0, 0, -1);
        chk("f055_done", 32'(done), 32'h1);
        chk("f055_data", 32'(data_out), 32'h055);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);

        frame(9'h1A5, 0, 11, -1);
        repeat (2 * N + 4) @(negedge clk_2x);
        chk("postrst_busy", 32'(busy), 32'h0);
        chk("postrst_data", 32'(data_out), 32'h0);
        chk("postrst_count", 32'(done_cnt), 32'd4);
        go = 1'b0;
        @(negedge clk_2x);
        frame(9'h0F0, 0, 0, -1);
        chk("f0f0_data", 32'(data_out), 32'h0F0);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);

        frame(9'h0A0, 0, 0, 3);
        chk("bad_done", 32'(done), 32'h1);
        chk("bad_data", 32'(data_out), 32'h0A8);
`ifdef MANCH_DEC_ERR_EN
        chk("bad_err", 32'(code_err), 32'h1);
`endif
        go = 1'b0;
        repeat (2) @(negedge clk_2x);
        frame(9'h133, 0, 0, -1);
        chk("clean_data", 32'(data_out), 32'h133);
`ifdef MANCH_DEC_ERR_EN
        chk("clean_err", 32'(code_err), 32'h0);
`endif
        go = 1'b0;
        repeat (2) @(negedge clk_2x);

        base_cnt = done_cnt;
        frame(9'h14B, 0, 0, -1);
        chk("hold_first", 32'(done), 32'h1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_2x);
            chk("hold_done", 32'(done), 32'h0);
            chk("hold_data", 32'(data_out), 32'h14B);
            chk("hold_busy", 32'(busy), 32'h0);
        end
        chk("hold_count", 32'(done_cnt - base_cnt), 32'd1);
        go = 1'b0;
        repeat (2) @(negedge clk_2x);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
